// File: rtl/line_pack_buffer.sv
// rtl/line_pack_buffer.sv - packs variable-length LSB-first chunks into dense LINE_W-bit lines
module line_pack_buffer #(
  parameter int IN_W   = 64,
  parameter int LINE_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic [$clog2(IN_W+1)-1:0] in_bits,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LINE_W-1:0]         out_data,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          line_count,
  output logic [CNT_W-1:0]          bit_count
);

  localparam int ACC_W  = LINE_W + IN_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] LINE_FILL = FILL_W'(LINE_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [FILL_W-1:0] fill;
  logic [ACC_W-1:0]  chunk_bits;
  logic [CNT_W:0]    bit_sum;
  logic              slot_free, accept, xfer_full, xfer_pad, finish;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer_full = (state != IDLE) && (fill >= LINE_FILL) && slot_free;
  assign xfer_pad  = (state == FLUSH) && (fill != '0) && (fill < LINE_FILL) && slot_free;
  assign finish    = (state == FLUSH) && (fill == '0) && slot_free;

  // Garbage above in_bits is masked before the chunk lands at the current fill point,
  // keeping everything at and above fill zero.
  assign chunk_bits = ({{LINE_W{1'b0}}, in_data} & ~({ACC_W{1'b1}} << in_bits)) << fill;
  assign bit_sum    = {1'b0, bit_count} + (CNT_W+1)'(in_bits);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && in_last) state_nxt = FLUSH;
      FLUSH:   if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (fill < LINE_FILL);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      fill       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
      line_count <= '0;
      bit_count  <= '0;
    end else begin
      done <= finish;
      if (state == IDLE && start) begin
        acc        <= '0;
        fill       <= '0;
        line_count <= '0;
        bit_count  <= '0;
      end else begin
        if (accept) begin
          acc       <= acc | chunk_bits;
          fill      <= fill + FILL_W'(in_bits);
          bit_count <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end else if (xfer_full) begin
          acc  <= acc >> LINE_W;
          fill <= fill - LINE_FILL;
        end else if (xfer_pad) begin
          acc  <= '0;
          fill <= '0;
        end
        if (out_valid && out_ready && line_count != '1)
          line_count <= line_count + 1'b1;
      end

      // Single output slot: a new line overwrites only when the old one is gone.
      if (xfer_full || xfer_pad) begin
        out_data  <= acc[LINE_W-1:0];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_pack_buffer.sv
// tb/tb_line_pack_buffer.sv - scoreboard bench for line_pack_buffer with a bit-queue reference model
module tb_line_pack_buffer;
  localparam int IN_W   = 64;
  localparam int LINE_W = 512;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [IN_W-1:0] in_data = '0;
  logic [6:0] in_bits = '0;
  logic in_ready, out_valid, busy, done;
  logic [LINE_W-1:0] out_data;
  logic [CNT_W-1:0] line_count, bit_count;

  line_pack_buffer #(.IN_W(IN_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bits(in_bits), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .line_count(line_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mq[$];
  logic [LINE_W-1:0] exp_q[$];
  int exp_lines = 0;
  longint exp_bits = 0;
  bit hold_low = 1'b0;
  bit bp_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [LINE_W-1:0] prev_data;

  function automatic void check(string nm, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void emit_line();
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < LINE_W && mq.size() > 0; i++) l[i] = mq.pop_front();
    exp_q.push_back(l);
    exp_lines++;
  endfunction

  function automatic void model_accept(logic [IN_W-1:0] d, int b, bit last);
    for (int i = 0; i < b; i++) mq.push_back(d[i]);
    exp_bits += b;
    while (mq.size() >= LINE_W) emit_line();
    if (last && mq.size() > 0) emit_line();
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", LINE_W'(out_valid), LINE_W'(1));
        check("hold_data", out_data, prev_data);
      end
      if (in_valid && in_ready) check("in_bits_legal", LINE_W'(in_bits <= IN_W), LINE_W'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_line: got %0h expected none", out_data);
        end else begin
          check("line", out_data, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send(input logic [IN_W-1:0] d, input int b, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bits  = 7'(b);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      model_accept(d, b, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_stream();
    mq.delete();
    exp_lines = 0;
    exp_bits  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_stream();
    int n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("done_seen", LINE_W'(done), LINE_W'(1));
    check("line_count", LINE_W'(line_count), LINE_W'(exp_lines));
    check("bit_count", LINE_W'(bit_count), LINE_W'(exp_bits));
    check("lines_outstanding", LINE_W'(exp_q.size()), LINE_W'(0));
    check("busy_at_done", LINE_W'(busy), LINE_W'(0));
    @(negedge clk);
    check("done_one_cycle", LINE_W'(done), LINE_W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic scenario1();
    start_stream();
    for (int k = 0; k < 8; k++) send(64'h1111_0000 + 64'(k), 64, k == 7);
    finish_stream();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", LINE_W'(out_valid), LINE_W'(0));
    check("rst_in_ready", LINE_W'(in_ready), LINE_W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_busy", LINE_W'(busy), LINE_W'(0));
    check("rst_done", LINE_W'(done), LINE_W'(0));
    check("rst_counts", LINE_W'({line_count, bit_count}), '0);
    @(posedge clk);
    #1;

    scenario1();

    start_stream();
    for (int k = 0; k < 10; k++) send(64'h0ABC_DEF0_1234_567 + 64'(k), 60, k == 9);
    finish_stream();

    hold_low = 1'b1;
    start_stream();
    fork
      for (int k = 0; k < 24; k++) send({$urandom, $urandom}, 64, k == 23);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", LINE_W'(in_ready), LINE_W'(0));
        check("stall_out_valid", LINE_W'(out_valid), LINE_W'(1));
        @(posedge clk);
        #1;
        hold_low = 1'b0;
      end
    join
    finish_stream();

    start_stream();
    for (int k = 0; k < 8; k++) send({$urandom, $urandom}, 64, 1'b0);
    send('0, 0, 1'b1);
    finish_stream();

    start_stream();
    send('1, 3, 1'b0);
    send('0, 0, 1'b1);
    finish_stream();

    start_stream();
    send('0, 0, 1'b1);
    finish_stream();

    start_stream();
    for (int k = 0; k < 5; k++) send(64'h1111_0000 + 64'(k), 64, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    exp_q.delete();
    @(negedge clk);
    check("abort_out_valid", LINE_W'(out_valid), LINE_W'(0));
    check("abort_in_ready", LINE_W'(in_ready), LINE_W'(0));
    check("abort_busy", LINE_W'(busy), LINE_W'(0));
    check("abort_counts", LINE_W'({line_count, bit_count}), '0);
    @(posedge clk);
    #1;
    scenario1();

    bp_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 30);
      start_stream();
      for (int k = 0; k < n; k++) begin
        if (s == 3 && k == n / 2) start = 1'b1;
        send({$urandom, $urandom}, $urandom_range(0, IN_W), k == n - 1);
        start = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      finish_stream();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
